// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg : opcodes, FSM state codes and instruction field positions for sr_core
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

  typedef enum logic [2:0] {
    OP_HALT = 3'd0,
    OP_MOVI = 3'd1,
    OP_MOV  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_BNZ  = 3'd6,
    OP_OUT  = 3'd7
  } op_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int OP_LSB   = 13;
  localparam int RD_LSB   = 10;
  localparam int RS_LSB   = 7;
  localparam int RT_LSB   = 4;
  localparam int OP_W     = 3;
  localparam int REG_W    = 3;
  localparam int IMM_W    = 8;
  localparam int NUM_REGS = 8;

endpackage

`default_nettype wire

// File: rtl/sr_if.sv
// ---------------------------------------------------------------------------
// sr_if : control, instruction-memory and result signals of sr_core
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sr_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_re;
  logic [15:0]       imem_rdata;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic [2:0]        flags;
  logic              busy;
  logic              halted;

  modport master (
    output start, start_pc, imem_rdata,
    input  imem_addr, imem_re, out, out_valid, flags, busy, halted
  );

  modport slave (
    input  start, start_pc, imem_rdata,
    output imem_addr, imem_re, out, out_valid, flags, busy, halted
  );
endinterface

`default_nettype wire

// File: rtl/sr_alu.sv
// ---------------------------------------------------------------------------
// sr_alu : combinational ADD/SUB/AND with {Z,N,V} flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_alu
  import sr_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        znv
);

  localparam int MSB = DATA_W - 1;

  logic ovf;

  // Overflow: operands effectively of equal sign but result sign differs
  always_comb begin
    result = a & b;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = a + b;
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      default: ;
    endcase
  end

  assign znv = {(result == '0), result[MSB], ovf};

endmodule

`default_nettype wire

// File: rtl/sr_core.sv
// ---------------------------------------------------------------------------
// sr_core : multi-cycle 8-register RISC core, FETCH/LOAD/DECODE/EXEC per instruction
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_core
  import sr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic clk,
  input  logic rst,
  sr_if.slave  bus
);

  logic [2:0]        state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] opc;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic [2:0]        flags_q;

  op_e               op;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [IMM_W-1:0]  imm8;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        alu_znv;

  assign op   = op_e'(ir[OP_LSB +: OP_W]);
  assign rd   = ir[RD_LSB +: REG_W];
  assign rs   = ir[RS_LSB +: REG_W];
  assign rt   = ir[RT_LSB +: REG_W];
  assign imm8 = ir[IMM_W-1:0];

  sr_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (opa),
    .b      (opb),
    .op     (op),
    .result (alu_res),
    .znv    (alu_znv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      opa         <= '0;
      opb         <= '0;
      opc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            pc    <= bus.start_pc;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ir    <= bus.imem_rdata;
          pc    <= pc + PC_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          opa   <= regs[rs];
          opb   <= regs[rt];
          opc   <= regs[rd];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= (op == OP_HALT) ? S_HALT : S_FETCH;
          case (op)
            OP_MOVI: regs[rd] <= DATA_W'(imm8);
            OP_MOV:  regs[rd] <= opa;
            OP_ADD, OP_SUB, OP_AND: begin
              regs[rd] <= alu_res;
              flags_q  <= alu_znv;
            end
            // A taken branch replaces the pc+1 already applied in LOAD
            OP_BNZ: if (opc != '0) pc <= PC_W'(imm8);
            OP_OUT: begin
              out_q       <= opa;
              out_valid_q <= 1'b1;
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.imem_re   = (state == S_FETCH);
  assign bus.busy      = (state == S_FETCH) || (state == S_LOAD) ||
                         (state == S_DECODE) || (state == S_EXEC);
  assign bus.halted    = (state == S_HALT);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_core.sv
// ---------------------------------------------------------------------------
// tb_sr_core : directed and random programs for sr_core against an instruction-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sr_core;

  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sr_if #(.DATA_W(16), .PC_W(8)) bus16 ();
  sr_if #(.DATA_W(32), .PC_W(8)) bus32 ();

  sr_core #(.DATA_W(16), .PC_W(8)) dut (.clk(clk), .rst(rst), .bus(bus16));
  sr_core #(.DATA_W(32), .PC_W(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  logic [15:0] mem16 [256];
  logic [15:0] mem32 [256];

  always @(posedge clk) if (bus16.imem_re) bus16.imem_rdata <= mem16[bus16.imem_addr];
  always @(posedge clk) if (bus32.imem_re) bus32.imem_rdata <= mem32[bus32.imem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] movi(input int rd, input int imm);
    return {3'd1, 3'(rd), 2'b00, 8'(imm)};
  endfunction
  function automatic logic [15:0] r3(input int op, input int rd, input int rs, input int rt);
    return {3'(op), 3'(rd), 3'(rs), 3'(rt), 4'b0000};
  endfunction
  function automatic logic [15:0] bnz(input int rd, input int tgt);
    return {3'd6, 3'(rd), 2'b00, 8'(tgt)};
  endfunction
  function automatic logic [15:0] outr(input int rs);
    return r3(7, 0, rs, 0);
  endfunction
  localparam logic [15:0] HALT = 16'h0000;

  // Instruction-level reference: executes a whole program from the memory image
  longint unsigned m_regs [8];
  logic [2:0]      m_flags;
  longint unsigned m_out;
  int              m_n;
  longint unsigned m_outs [$];
  int              m_fetch [$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_flags = 3'b000;
    m_out   = 0;
  endtask

  task automatic model_run(input int pc0);
    longint unsigned mask, half, a, b, res;
    longint sa, sb, s;
    bit v, done;
    int pc, op, rd, rs, rt;
    logic [15:0] ins;
    mask = (64'd1 << MW) - 1;
    half = 64'd1 << (MW - 1);
    pc = pc0;
    done = 0;
    m_n = 0;
    m_outs.delete();
    m_fetch.delete();
    while (!done && m_n < 4000) begin
      ins = mem16[pc];
      m_fetch.push_back(pc);
      pc = (pc + 1) % 256;
      m_n++;
      op = int'(ins[15:13]); rd = int'(ins[12:10]);
      rs = int'(ins[9:7]);   rt = int'(ins[6:4]);
      a = m_regs[rs];
      b = m_regs[rt];
      sa = (a >= half) ? longint'(a) - longint'(mask) - 1 : longint'(a);
      sb = (b >= half) ? longint'(b) - longint'(mask) - 1 : longint'(b);
      case (op)
        0: done = 1;
        1: m_regs[rd] = 64'(ins[7:0]);
        2: m_regs[rd] = a;
        3, 4, 5: begin
          v = 0;
          if (op == 3) begin
            res = (a + b) & mask; s = sa + sb;
            v = (s > longint'(half) - 1) || (s < -longint'(half));
          end else if (op == 4) begin
            res = (a - b) & mask; s = sa - sb;
            v = (s > longint'(half) - 1) || (s < -longint'(half));
          end else begin
            res = a & b;
          end
          m_regs[rd] = res;
          m_flags = {res == 0, res >= half, v};
        end
        6: if (m_regs[rd] != 0) pc = int'(ins[7:0]);
        default: begin
          m_out = a;
          m_outs.push_back(a);
        end
      endcase
    end
  endtask

  longint unsigned d_outs [$];
  int              d_fetch [$];
  int              last_cyc;

  task automatic sample16();
    if (bus16.imem_re) d_fetch.push_back(int'(bus16.imem_addr));
    if (bus16.out_valid) d_outs.push_back(64'(bus16.out));
  endtask

  task automatic run_prog(input int pc0, input bit poke, input string tag);
    int cyc, budget;
    model_run(pc0);
    budget = 4 * m_n + 40;
    d_outs.delete();
    d_fetch.delete();
    @(negedge clk);
    bus16.start_pc = 8'(pc0);
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    cyc = 1;
    sample16();
    while (!bus16.halted && cyc < budget) begin
      // A start pulse while busy must not disturb execution
      if (poke && cyc == 3) begin
        bus16.start = 1'b1;
        bus16.start_pc = 8'($urandom);
      end else begin
        bus16.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      sample16();
    end
    bus16.start = 1'b0;
    last_cyc = cyc;
    check({tag, "_halted"}, 64'(bus16.halted), 64'd1);
    check({tag, "_cycles"}, 64'(cyc), 64'(1 + 4 * m_n));
    check({tag, "_busy"}, 64'(bus16.busy), 64'd0);
    check({tag, "_out"}, 64'(bus16.out), m_out);
    check({tag, "_flags"}, 64'(bus16.flags), 64'(m_flags));
    check({tag, "_nout"}, 64'(d_outs.size()), 64'(m_outs.size()));
    for (int i = 0; i < d_outs.size() && i < m_outs.size(); i++)
      check({tag, "_outval"}, d_outs[i], m_outs[i]);
    check({tag, "_nfetch"}, 64'(d_fetch.size()), 64'(m_fetch.size()));
    for (int i = 0; i < d_fetch.size() && i < m_fetch.size(); i++)
      check({tag, "_fetch"}, 64'(d_fetch[i]), 64'(m_fetch[i]));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_out"}, 64'(bus16.out), 64'd0);
    check({tag, "_out_valid"}, 64'(bus16.out_valid), 64'd0);
    check({tag, "_flags"}, 64'(bus16.flags), 64'd0);
    check({tag, "_busy"}, 64'(bus16.busy), 64'd0);
    check({tag, "_halted"}, 64'(bus16.halted), 64'd0);
    check({tag, "_imem_re"}, 64'(bus16.imem_re), 64'd0);
    check({tag, "_imem_addr"}, 64'(bus16.imem_addr), 64'd0);
  endtask

  initial begin
    int pc0, len, k, cyc32, pulses32;
    logic [15:0] ins;

    for (int i = 0; i < 256; i++) begin
      mem16[i] = HALT;
      mem32[i] = HALT;
    end
    rst = 1'b1;
    bus16.start = 1'b0; bus16.start_pc = '0;
    bus32.start = 1'b0; bus32.start_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    model_reset();

    // Minimal program: three instructions, halted 13 cycles after start
    mem16[0] = movi(0, 1); mem16[1] = outr(0); mem16[2] = HALT;
    run_prog(0, 0, "halt_fetch");
    check("halt_fetch_cyc13", 64'(last_cyc), 64'd13);
    check("halt_fetch_out1", 64'(bus16.out), 64'h0001);
    check("halt_fetch_pulses", 64'(d_outs.size()), 64'd1);

    mem16[16] = movi(1, 0); mem16[17] = movi(2, 1); mem16[18] = r3(4, 3, 1, 2);
    mem16[19] = outr(3); mem16[20] = HALT;
    run_prog(16, 0, "sub_flags");
    check("sub_flags_out", 64'(bus16.out), 64'hFFFF);
    check("sub_flags_znv", 64'(bus16.flags), 64'b010);

    mem16[32] = movi(1, 3); mem16[33] = movi(2, 1); mem16[34] = r3(4, 1, 1, 2);
    mem16[35] = bnz(1, 34); mem16[36] = outr(1); mem16[37] = HALT;
    run_prog(32, 0, "loop");
    check("loop_out", 64'(bus16.out), 64'd0);
    check("loop_znv", 64'(bus16.flags), 64'b100);

    mem16[255] = movi(0, 5); mem16[0] = outr(0); mem16[1] = HALT;
    run_prog(255, 0, "wrap");
    check("wrap_out", 64'(bus16.out), 64'd5);
    if (d_fetch.size() >= 3) begin
      check("wrap_addr0", 64'(d_fetch[0]), 64'hFF);
      check("wrap_addr1", 64'(d_fetch[1]), 64'h00);
      check("wrap_addr2", 64'(d_fetch[2]), 64'h01);
    end else begin
      check("wrap_fetch_len", 64'(d_fetch.size()), 64'd3);
    end

    // Restart from HALT: r0 still holds 5
    mem16[4] = outr(0); mem16[5] = HALT;
    run_prog(4, 1, "restart");
    check("restart_out", 64'(bus16.out), 64'd5);

    for (int t = 0; t < 12; t++) begin
      pc0 = $urandom_range(0, 255);
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) begin
        k = $urandom_range(0, 5);
        case (k)
          0: ins = movi($urandom_range(0, 7), $urandom_range(0, 255));
          1: ins = r3(2, $urandom_range(0, 7), $urandom_range(0, 7), 0);
          2: ins = r3(3, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
          3: ins = r3(4, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
          4: ins = r3(5, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
          default: ins = outr($urandom_range(0, 7));
        endcase
        mem16[(pc0 + i) % 256] = ins;
      end
      mem16[(pc0 + len) % 256] = outr($urandom_range(0, 7));
      mem16[(pc0 + len + 1) % 256] = HALT;
      run_prog(pc0, (t % 2 == 1), "rand");
    end

    // Reset asserted while the ADD is in EXEC
    mem16[64] = movi(1, 5); mem16[65] = outr(1); mem16[66] = r3(3, 2, 1, 1); mem16[67] = HALT;
    @(negedge clk);
    bus16.start_pc = 8'd64;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(bus16.busy), 64'd1);
    check("pre_rst_out", 64'(bus16.out), 64'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst_exec");
    rst = 1'b0;
    model_reset();
    mem16[80] = outr(1); mem16[81] = HALT;
    run_prog(80, 0, "post_rst");
    check("post_rst_regs_cleared", 64'(bus16.out), 64'd0);

    // 32-bit instance
    mem32[0] = movi(0, 255); mem32[1] = r3(3, 0, 0, 0); mem32[2] = outr(0); mem32[3] = HALT;
    @(negedge clk);
    bus32.start_pc = 8'd0;
    bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    cyc32 = 1;
    pulses32 = 0;
    while (!bus32.halted && cyc32 < 100) begin
      @(posedge clk); #1;
      cyc32++;
      if (bus32.out_valid) pulses32++;
    end
    check("w32_halted", 64'(bus32.halted), 64'd1);
    check("w32_out", 64'(bus32.out), 64'h0000_01FE);
    check("w32_flags", 64'(bus32.flags), 64'b000);
    check("w32_pulses", 64'(pulses32), 64'd1);
    check("w32_cycles", 64'(cyc32), 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
